// File: rtl/lvds_align_pkg.sv
// Shared definitions for the LVDS word-alignment controller: state encoding,
// the K28.5 comma character and the slip-position modulus.
package lvds_align_pkg;

  typedef enum logic [2:0] {
    StWaitLock = 3'd0,
    StHunt     = 3'd1,
    StSlip     = 3'd2,
    StSettle   = 3'd3,
    StAcq      = 3'd4,
    StLocked   = 3'd5
  } state_e;

  localparam logic [7:0]  K28_5    = 8'hBC;
  localparam int unsigned SLIP_MOD = 10;

  // Slip position after one more bit slip; the deserializer ratio is 10.
  function automatic logic [3:0] next_slip_pos(input logic [3:0] pos);
    return (pos == 4'(SLIP_MOD - 1)) ? 4'd0 : pos + 4'd1;
  endfunction

endpackage

// File: rtl/lvds_word_align_ctrl_if.sv
// Bundle of the decoder-facing and status signals around the word-alignment
// controller. master = receiver/decoder side, slave = alignment controller.
interface lvds_word_align_ctrl_if;
  logic        pll_locked;
  logic [7:0]  rx_code_group;
  logic        rx_code_ctrl;
  logic        rx_code_invalid;
  logic        rx_bit_slip;
  logic        aligned;
  logic [2:0]  state;
  logic [3:0]  slip_pos;
  logic [15:0] slip_total;
  logic [15:0] loss_count;

  modport master (
    output pll_locked, rx_code_group, rx_code_ctrl, rx_code_invalid,
    input  rx_bit_slip, aligned, state, slip_pos, slip_total, loss_count
  );

  modport slave (
    input  pll_locked, rx_code_group, rx_code_ctrl, rx_code_invalid,
    output rx_bit_slip, aligned, state, slip_pos, slip_total, loss_count
  );
endinterface

// File: rtl/lvds_word_align_ctrl.sv
// LVDS receiver word-alignment controller. Hunts for K28.5 commas, pulses the
// receiver bit-slip input to walk through the 10 slip positions, qualifies
// alignment over several clean commas and drops it on accumulated errors.
// Optional statistics counters are built when LVDS_ALIGN_STATS_EN is defined;
// otherwise the statistics ports are tied to zero.
module lvds_word_align_ctrl
  import lvds_align_pkg::*;
#(
  parameter int unsigned HUNT_WIN  = 64,
  parameter int unsigned GOOD_CNT  = 4,
  parameter int unsigned BAD_CNT   = 4,
  parameter int unsigned SLIP_HOLD = 8
) (
  input  logic        i_Clk,
  input  logic        i_ARst_L,
  input  logic        i_PllLocked,
  input  logic [7:0]  i8_RxCodeGroup,
  input  logic        i_RxCodeCtrl,
  input  logic        i_RxCodeInvalid,
  output logic        o_RxBitSlip,
  output logic        o_Aligned,
  output logic [2:0]  o3_State,
  output logic [3:0]  o4_SlipPos,
  output logic [15:0] o16_SlipTotal,
  output logic [15:0] o16_LossCount
);

  localparam int unsigned WinW  = (HUNT_WIN > 1) ? $clog2(HUNT_WIN) : 1;
  localparam int unsigned GoodW = $clog2(GOOD_CNT + 1);
  localparam int unsigned ErrW  = $clog2(BAD_CNT + 1);
  localparam int unsigned SetW  = (SLIP_HOLD > 1) ? $clog2(SLIP_HOLD) : 1;

  localparam logic [WinW-1:0]  WinLast  = WinW'(HUNT_WIN - 1);
  localparam logic [GoodW-1:0] GoodLast = GoodW'(GOOD_CNT - 1);
  localparam logic [ErrW-1:0]  ErrLast  = ErrW'(BAD_CNT - 1);
  localparam logic [SetW-1:0]  SetLast  = SetW'(SLIP_HOLD - 1);

  state_e           state_q;
  logic [WinW-1:0]  win_q;
  logic [GoodW-1:0] good_q;
  logic [ErrW-1:0]  err_q;
  logic [SetW-1:0]  settle_q;
  logic             slip_cyc_q;
  logic [3:0]       slip_pos_q;
  logic             bitslip_q;
  logic             aligned_q;

  logic comma;
  logic slip_ev;
  logic loss_ev;

  // Decode comma and the transition events shared by the FSM and statistics.
  always_comb begin
    comma   = i_RxCodeCtrl && (i8_RxCodeGroup == K28_5) && !i_RxCodeInvalid;
    slip_ev = i_PllLocked &&
              (((state_q == StHunt) && !comma && (i_RxCodeInvalid || (win_q == WinLast))) ||
               ((state_q == StAcq) && i_RxCodeInvalid));
    loss_ev = (state_q == StLocked) &&
              (!i_PllLocked || (i_RxCodeInvalid && (err_q == ErrLast)));
  end

  // Alignment FSM with its counters and registered slip/aligned outputs.
  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      state_q    <= StWaitLock;
      win_q      <= '0;
      good_q     <= '0;
      err_q      <= '0;
      settle_q   <= '0;
      slip_cyc_q <= 1'b0;
      slip_pos_q <= '0;
      bitslip_q  <= 1'b0;
      aligned_q  <= 1'b0;
    end else if (!i_PllLocked) begin
      // Lock loss wins over everything, including a slip pulse in flight.
      state_q    <= StWaitLock;
      win_q      <= '0;
      good_q     <= '0;
      err_q      <= '0;
      settle_q   <= '0;
      slip_cyc_q <= 1'b0;
      bitslip_q  <= 1'b0;
      aligned_q  <= 1'b0;
    end else if (slip_ev) begin
      state_q    <= StSlip;
      slip_cyc_q <= 1'b0;
      bitslip_q  <= 1'b1;
      slip_pos_q <= next_slip_pos(slip_pos_q);
    end else begin
      unique case (state_q)
        StWaitLock: begin
          state_q <= StHunt;
          win_q   <= '0;
        end
        StHunt: begin
          if (comma) begin
            state_q <= StAcq;
            good_q  <= GoodW'(1);
          end else begin
            win_q <= win_q + WinW'(1);
          end
        end
        StSlip: begin
          // Pulse lasts two cycles: the entry cycle plus one more.
          if (slip_cyc_q) begin
            state_q   <= StSettle;
            bitslip_q <= 1'b0;
            settle_q  <= '0;
          end else begin
            slip_cyc_q <= 1'b1;
          end
        end
        StSettle: begin
          if (settle_q == SetLast) begin
            state_q <= StHunt;
            win_q   <= '0;
          end else begin
            settle_q <= settle_q + SetW'(1);
          end
        end
        StAcq: begin
          if (comma) begin
            if (good_q == GoodLast) begin
              state_q   <= StLocked;
              aligned_q <= 1'b1;
              err_q     <= '0;
            end else begin
              good_q <= good_q + GoodW'(1);
            end
          end
        end
        StLocked: begin
          if (i_RxCodeInvalid) begin
            if (err_q == ErrLast) begin
              state_q   <= StHunt;
              aligned_q <= 1'b0;
              win_q     <= '0;
              good_q    <= '0;
              err_q     <= '0;
            end else begin
              err_q <= err_q + ErrW'(1);
            end
          end else if (comma && (err_q != '0)) begin
            err_q <= err_q - ErrW'(1);
          end
        end
        default: begin
          state_q <= StWaitLock;
        end
      endcase
    end
  end

  assign o_RxBitSlip = bitslip_q;
  assign o_Aligned   = aligned_q;
  assign o3_State    = state_q;
  assign o4_SlipPos  = slip_pos_q;

`ifdef LVDS_ALIGN_STATS_EN
  logic [15:0] slip_total_q;
  logic [15:0] loss_cnt_q;

  // Saturating slip and alignment-loss counters.
  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      slip_total_q <= '0;
      loss_cnt_q   <= '0;
    end else begin
      if (slip_ev && (slip_total_q != 16'hFFFF)) begin
        slip_total_q <= slip_total_q + 16'd1;
      end
      if (loss_ev && (loss_cnt_q != 16'hFFFF)) begin
        loss_cnt_q <= loss_cnt_q + 16'd1;
      end
    end
  end

  assign o16_SlipTotal = slip_total_q;
  assign o16_LossCount = loss_cnt_q;
`else
  assign o16_SlipTotal = '0;
  assign o16_LossCount = '0;
`endif

endmodule

// File: tb/tb_lvds_word_align_ctrl.sv
// Directed bench for lvds_word_align_ctrl: reset values, hunt-window slips
// through all ten positions, a cycle-by-cycle acquisition/lock/error table,
// slip abort on lock loss and asynchronous reset while locked.
module tb_lvds_word_align_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lvds_word_align_ctrl_if bus ();

  lvds_word_align_ctrl dut (
    .i_Clk           (clk),
    .i_ARst_L        (rst_n),
    .i_PllLocked     (bus.pll_locked),
    .i8_RxCodeGroup  (bus.rx_code_group),
    .i_RxCodeCtrl    (bus.rx_code_ctrl),
    .i_RxCodeInvalid (bus.rx_code_invalid),
    .o_RxBitSlip     (bus.rx_bit_slip),
    .o_Aligned       (bus.aligned),
    .o3_State        (bus.state),
    .o4_SlipPos      (bus.slip_pos),
    .o16_SlipTotal   (bus.slip_total),
    .o16_LossCount   (bus.loss_count)
  );

`ifdef LVDS_ALIGN_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  typedef struct {
    logic       lock;
    logic [7:0] grp;
    logic       ctrl;
    logic       inv;
    logic [2:0] st;
    logic       slip;
    logic       al;
    logic [3:0] pos;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t tbl[33];

  function automatic vec_t v(input logic lock, input logic [7:0] g, input logic c,
                             input logic i, input logic [2:0] s, input logic sl,
                             input logic a, input logic [3:0] p);
    vec_t r;
    r.lock = lock; r.grp = g; r.ctrl = c; r.inv = i;
    r.st = s; r.slip = sl; r.al = a; r.pos = p;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, sample 1 ns after the rising edge.
  task automatic cycle(input logic lock, input logic [7:0] g, input logic c, input logic i);
    @(negedge clk);
    bus.pll_locked      = lock;
    bus.rx_code_group   = g;
    bus.rx_code_ctrl    = c;
    bus.rx_code_invalid = i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [15:0] exp_slips;
    logic [15:0] exp_loss;

    // Cycle-by-cycle table: acquisition, locked error counting, ACQ abort,
    // settle ignoring inputs, good-count restart, lock loss.
    tbl[0]  = v(1, 8'h00, 0, 0, 3'd1, 0, 0, 4'd0);
    tbl[1]  = v(1, 8'hBC, 1, 0, 3'd4, 0, 0, 4'd0);
    tbl[2]  = v(1, 8'hBC, 0, 0, 3'd4, 0, 0, 4'd0);
    tbl[3]  = v(1, 8'hBC, 1, 0, 3'd4, 0, 0, 4'd0);
    tbl[4]  = v(1, 8'hBC, 1, 0, 3'd4, 0, 0, 4'd0);
    tbl[5]  = v(1, 8'h3C, 1, 0, 3'd4, 0, 0, 4'd0);
    tbl[6]  = v(1, 8'hBC, 1, 0, 3'd5, 0, 1, 4'd0);
    tbl[7]  = v(1, 8'hBC, 1, 1, 3'd5, 0, 1, 4'd0);
    tbl[8]  = v(1, 8'hBC, 1, 0, 3'd5, 0, 1, 4'd0);
    tbl[9]  = v(1, 8'hBC, 1, 1, 3'd5, 0, 1, 4'd0);
    tbl[10] = v(1, 8'hBC, 1, 1, 3'd5, 0, 1, 4'd0);
    tbl[11] = v(1, 8'hBC, 1, 1, 3'd5, 0, 1, 4'd0);
    tbl[12] = v(1, 8'hBC, 1, 1, 3'd1, 0, 0, 4'd0);
    tbl[13] = v(1, 8'hBC, 0, 0, 3'd1, 0, 0, 4'd0);
    tbl[14] = v(1, 8'hBC, 1, 0, 3'd4, 0, 0, 4'd0);
    tbl[15] = v(1, 8'hBC, 1, 0, 3'd4, 0, 0, 4'd0);
    tbl[16] = v(1, 8'hBC, 1, 0, 3'd4, 0, 0, 4'd0);
    tbl[17] = v(1, 8'hBC, 1, 1, 3'd2, 1, 0, 4'd1);
    tbl[18] = v(1, 8'h00, 0, 0, 3'd2, 1, 0, 4'd1);
    tbl[19] = v(1, 8'h00, 0, 0, 3'd3, 0, 0, 4'd1);
    tbl[20] = v(1, 8'hBC, 1, 0, 3'd3, 0, 0, 4'd1);
    tbl[21] = v(1, 8'hBC, 1, 1, 3'd3, 0, 0, 4'd1);
    for (int i = 22; i < 27; i++) tbl[i] = v(1, 8'h00, 0, 0, 3'd3, 0, 0, 4'd1);
    tbl[27] = v(1, 8'h00, 0, 0, 3'd1, 0, 0, 4'd1);
    tbl[28] = v(1, 8'hBC, 1, 0, 3'd4, 0, 0, 4'd1);
    tbl[29] = v(1, 8'hBC, 1, 0, 3'd4, 0, 0, 4'd1);
    tbl[30] = v(1, 8'hBC, 1, 0, 3'd4, 0, 0, 4'd1);
    tbl[31] = v(1, 8'hBC, 1, 0, 3'd5, 0, 1, 4'd1);
    tbl[32] = v(0, 8'h00, 0, 0, 3'd0, 0, 0, 4'd1);

    bus.pll_locked = 1'b0;
    bus.rx_code_group = 8'h00;
    bus.rx_code_ctrl = 1'b0;
    bus.rx_code_invalid = 1'b0;

    // Reset values.
    #1 rst_n = 1'b0;
    #11;
    chk("rst_state", bus.state, 3'd0);
    chk("rst_slip", bus.rx_bit_slip, 1'b0);
    chk("rst_aligned", bus.aligned, 1'b0);
    chk("rst_pos", bus.slip_pos, 4'd0);
    chk("rst_slip_total", bus.slip_total, 16'd0);
    chk("rst_loss", bus.loss_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // No commas at all: ten full windows walk the slip position back to 0.
    cycle(1, 8'h00, 0, 0);
    for (int w = 0; w < 10; w++) begin
      n = 0;
      while (bus.state == 3'd1 && n < 300) begin n++; cycle(1, 8'h00, 0, 0); end
      chk("hunt_len", n, 64);
      chk("slip_pos_step", bus.slip_pos, (w + 1) % 10);
      n = 0;
      while (bus.rx_bit_slip && n < 20) begin n++; cycle(1, 8'h00, 0, 0); end
      chk("slip_width", n, 2);
      n = 0;
      while (bus.state == 3'd3 && n < 50) begin n++; cycle(1, 8'h00, 0, 0); end
      chk("settle_len", n, 8);
    end
    chk("hunt_resumed", bus.state, 3'd1);
    chk("pos_wrapped", bus.slip_pos, 4'd0);

    cycle(0, 8'h00, 0, 0);
    chk("lock_drop_state", bus.state, 3'd0);

    for (int i = 0; i < 33; i++) begin
      cycle(tbl[i].lock, tbl[i].grp, tbl[i].ctrl, tbl[i].inv);
      chk($sformatf("tbl%0d_state", i), bus.state, tbl[i].st);
      chk($sformatf("tbl%0d_slip", i), bus.rx_bit_slip, tbl[i].slip);
      chk($sformatf("tbl%0d_aligned", i), bus.aligned, tbl[i].al);
      chk($sformatf("tbl%0d_pos", i), bus.slip_pos, tbl[i].pos);
    end

    exp_slips = StatsOn ? 16'd11 : 16'd0;
    exp_loss  = StatsOn ? 16'd2 : 16'd0;
    chk("stats_slip_total", bus.slip_total, exp_slips);
    chk("stats_loss", bus.loss_count, exp_loss);

    // Lock loss during the first slip-pulse cycle aborts the pulse.
    cycle(1, 8'h00, 0, 0);
    chk("relock_hunt", bus.state, 3'd1);
    cycle(1, 8'hBC, 1, 1);
    chk("abort_slip_on", bus.rx_bit_slip, 1'b1);
    chk("abort_pos", bus.slip_pos, 4'd2);
    cycle(0, 8'h00, 0, 0);
    chk("abort_slip_off", bus.rx_bit_slip, 1'b0);
    chk("abort_state", bus.state, 3'd0);
    cycle(1, 8'h00, 0, 0);
    chk("abort_relock", bus.state, 3'd1);

    // Lock again, then assert reset between clock edges.
    for (int i = 0; i < 4; i++) cycle(1, 8'hBC, 1, 0);
    chk("relocked", bus.state, 3'd5);
    chk("relocked_aligned", bus.aligned, 1'b1);
    exp_slips = StatsOn ? 16'd12 : 16'd0;
    chk("stats_slip_total2", bus.slip_total, exp_slips);
    #3 rst_n = 1'b0;
    #1;
    chk("async_state", bus.state, 3'd0);
    chk("async_aligned", bus.aligned, 1'b0);
    chk("async_slip", bus.rx_bit_slip, 1'b0);
    chk("async_pos", bus.slip_pos, 4'd0);
    chk("async_slip_total", bus.slip_total, 16'd0);
    chk("async_loss", bus.loss_count, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lvds_word_align_ctrl.md
LVDS_WORD_ALIGN_CTRL -- requirements
Module: lvds_word_align_ctrl

Interface
REQ-001 SHALL have parameter HUNT_WIN, default 64: cycles allowed to find a comma per slip position.
REQ-002 SHALL have parameter GOOD_CNT, default 4: consecutive clean commas required to declare alignment.
REQ-003 SHALL have parameter BAD_CNT, default 4: net error count that drops alignment.
REQ-004 SHALL have parameter SLIP_HOLD, default 8: settle cycles after each slip pulse.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port i_Clk, input, 1 bit: recovered core clock (divided forward clock).
REQ-007 SHALL have port i_ARst_L, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port i_PllLocked, input, 1 bit: LVDS receiver PLL lock.
REQ-009 SHALL have port i8_RxCodeGroup, input, 8 bits: decoded code group.
REQ-010 SHALL have port i_RxCodeCtrl, input, 1 bit: decoded K flag.
REQ-011 SHALL have port i_RxCodeInvalid, input, 1 bit: code or disparity error.
REQ-012 SHALL have port o_RxBitSlip, output, 1 bit: drives the receiver data-align input.
REQ-013 SHALL have port o_Aligned, output, 1 bit: word alignment achieved.
REQ-014 SHALL have port o3_State, output, 3 bits: current FSM state encoding.
REQ-015 SHALL have port o4_SlipPos, output, 4 bits: slip position, range 0..9.
REQ-016 SHALL have port o16_SlipTotal, output, 16 bits: statistics counter (see Configuration).
REQ-017 SHALL have port o16_LossCount, output, 16 bits: statistics counter (see Configuration).

Function
REQ-018 SHALL define a comma as i_RxCodeCtrl=1 and i8_RxCodeGroup=8'hBC (K28.5) and i_RxCodeInvalid=0.
REQ-019 SHALL use states WAIT_LOCK=0, HUNT=1, SLIP=2, SETTLE=3, ACQ=4 and LOCKED=5, with o3_State equal to the state encoding.
REQ-020 WAIT_LOCK SHALL go to HUNT on the first cycle i_PllLocked=1, clearing the window counter.
REQ-021 HUNT SHALL go to ACQ on a comma (good count=1), and to SLIP on any invalid code or when the window counter reaches HUNT_WIN-1 with no comma.
REQ-022 SLIP SHALL hold o_RxBitSlip=1 for exactly 2 cycles, then go to SETTLE; o4_SlipPos SHALL increment on entry to SLIP, wrapping 9->0.
REQ-023 SETTLE SHALL ignore all decoder inputs for SLIP_HOLD cycles, then go to HUNT with the window counter cleared.
REQ-024 ACQ SHALL increment the good count on each comma, go to LOCKED when it reaches GOOD_CNT, and go to SLIP on any invalid code; non-comma valid codes SHALL neither count nor reset the good count.
REQ-025 LOCKED SHALL drive o_Aligned=1 and maintain an error counter: +1 on invalid, -1 on comma (floor 0), unchanged when both or neither apply.
REQ-026 LOCKED SHALL go to HUNT when the error counter reaches BAD_CNT, and o_Aligned SHALL fall in the same cycle as the state change.
REQ-027 In any state, i_PllLocked=0 SHALL force WAIT_LOCK on the next cycle, with o_RxBitSlip=0, o_Aligned=0 and all counters except o4_SlipPos and the statistics counters cleared; this SHALL abort an in-progress slip pulse.
REQ-028 o_RxBitSlip and o_Aligned SHALL be registered outputs, never combinational from inputs.

Reset
REQ-029 On i_ARst_L=0 the block SHALL enter WAIT_LOCK asynchronously.
REQ-030 On reset, o_RxBitSlip=0, o_Aligned=0, o3_State=0, o4_SlipPos=0, o16_SlipTotal=0 and o16_LossCount=0.
REQ-031 Reset release SHALL take effect at the first i_Clk rising edge after deassertion.

Configuration
REQ-032 With macro LVDS_ALIGN_STATS_EN defined: o16_SlipTotal SHALL increment on each SLIP entry, o16_LossCount SHALL increment on each LOCKED->HUNT or LOCKED->WAIT_LOCK transition, and both SHALL saturate at 16'hFFFF.
REQ-033 Without LVDS_ALIGN_STATS_EN: both statistics ports SHALL be tied to 0 and no counter logic SHALL be synthesized.

Structure
REQ-034 Package lvds_align_pkg SHALL hold the state typedef/encoding, the K28.5 constant 8'hBC and the slip-position modulus 10.
REQ-035 SHALL be a single module with no sub-module; the counters are inline.

Verification
REQ-036 Reset, then lock=1 with commas every 10 cycles and no errors -> LOCKED after 4 commas, o_Aligned=1, o4_SlipPos=0, no slip pulse.
REQ-037 Lock=1, no commas for 64 cycles -> 2-cycle o_RxBitSlip pulse, o4_SlipPos=1, 8 settle cycles, HUNT resumes; after 10 failed windows o4_SlipPos=0.
REQ-038 ACQ with 3 commas, then 1 invalid -> SLIP entered, good count restarts at next HUNT.
REQ-039 LOCKED: inject invalid, comma, invalid, invalid, invalid -> counter 1,0,1,2,3 stays locked; a fourth invalid -> o_Aligned=0, HUNT; with stats o16_LossCount=1.
REQ-040 Drop i_PllLocked during the first slip-pulse cycle -> o_RxBitSlip=0 next cycle, state WAIT_LOCK; relock -> HUNT.
REQ-041 Assert i_ARst_L=0 mid-LOCKED between clock edges -> all outputs zero immediately, state 0.
